// File: rtl/frame_seq_ctrl_if.sv
// rtl/frame_seq_ctrl_if.sv - beat handshake and per-beat qualifier bundle for frame_seq_ctrl
interface frame_seq_ctrl_if #(
    parameter int BEAT_CNT_W = 16
);
    logic                  beat_accept;
    logic                  tlast;
    logic                  tuser_err;
    logic                  header_done;
    logic                  frame_start;
    logic                  frame_end;
    logic                  frame_err;
    logic [1:0]            err_code;
    logic                  beat_is_hdr;
    logic                  beat_is_pay;
    logic [BEAT_CNT_W-1:0] beat_idx;

    modport master (
        output beat_accept, tlast, tuser_err, header_done,
        input  frame_start, frame_end, frame_err, err_code,
               beat_is_hdr, beat_is_pay, beat_idx
    );

    modport slave (
        input  beat_accept, tlast, tuser_err, header_done,
        output frame_start, frame_end, frame_err, err_code,
               beat_is_hdr, beat_is_pay, beat_idx
    );
endinterface

// File: rtl/frame_seq_ctrl.sv
// rtl/frame_seq_ctrl.sv - per-frame IDLE/HEADER/PAYLOAD/DROP tracker with error detection and stats
module frame_seq_ctrl #(
    parameter int BEAT_CNT_W   = 16,
    parameter int HDR_CNT_W    = 4,
    parameter int STAT_W       = 32,
    parameter int EXT_HDR_DONE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    frame_seq_ctrl_if.slave       bus,
    input  logic [HDR_CNT_W-1:0]  cfg_hdr_beats,
    input  logic [BEAT_CNT_W-1:0] cfg_max_beats,
    input  logic                  clr_stats,
    output logic                  in_header,
    output logic                  in_payload,
    output logic                  in_drop,
    output logic [STAT_W-1:0]     frames_ok,
    output logic [STAT_W-1:0]     frames_err
);

    localparam int CMP_W = (BEAT_CNT_W > HDR_CNT_W) ? BEAT_CNT_W : HDR_CNT_W;
    localparam logic [BEAT_CNT_W-1:0] BEAT_ONE = {{(BEAT_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [HDR_CNT_W-1:0]  HDR_ONE  = {{(HDR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STAT_W-1:0]     STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_RUNT     = 2'd1;
    localparam logic [1:0] ERR_OVERSIZE = 2'd2;
    localparam logic [1:0] ERR_ABORT    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2,
        S_DROP    = 2'd3
    } state_t;

    state_t                  state;
    logic [BEAT_CNT_W-1:0]   beat_cnt;
    logic [HDR_CNT_W-1:0]    hdr_lat;
    logic [BEAT_CNT_W-1:0]   max_lat;
    logic [1:0]              sticky_code;

    logic                    acc;
    logic                    idle;
    logic                    hdr_phase;
    logic [HDR_CNT_W-1:0]    hdr_cfg;
    logic [BEAT_CNT_W-1:0]   max_cfg;
    logic [HDR_CNT_W-1:0]    hdr_last;
    logic                    hdr_end;
    logic                    abort;
    logic                    oversize;
    logic                    runt;
    logic [1:0]              beat_code;

    assign acc       = bus.beat_accept;
    assign idle      = (state == S_IDLE);
    assign hdr_phase = idle || (state == S_HEADER);

    // Config is taken live on the first beat and from the latched copy afterwards
    assign hdr_cfg  = idle ? cfg_hdr_beats : hdr_lat;
    assign max_cfg  = idle ? cfg_max_beats : max_lat;
    assign hdr_last = (hdr_cfg == '0) ? '0 : (hdr_cfg - HDR_ONE);

    // Decode header end, error conditions and the prioritised per-beat code
    always_comb begin
        hdr_end = 1'b0;
        if (EXT_HDR_DONE != 0) begin
            hdr_end = bus.header_done;
        end else begin
            hdr_end = (CMP_W'(beat_cnt) == CMP_W'(hdr_last));
        end
        abort    = bus.tuser_err;
        oversize = (max_cfg != '0) && (beat_cnt >= max_cfg);
        runt     = bus.tlast && (state != S_PAYLOAD);
        if (abort) begin
            beat_code = ERR_ABORT;
        end else if (oversize) begin
            beat_code = ERR_OVERSIZE;
        end else if (runt) begin
            beat_code = ERR_RUNT;
        end else begin
            beat_code = ERR_OK;
        end
    end

    // Per-beat qualifiers; all pulses stay low on cycles without an accepted beat
    always_comb begin
        bus.frame_start = acc && idle;
        bus.frame_end   = acc && bus.tlast;
        bus.err_code    = ERR_OK;
        if (bus.frame_end) begin
            bus.err_code = (state == S_DROP) ? sticky_code : beat_code;
        end
        bus.frame_err   = bus.frame_end && (bus.err_code != ERR_OK);
        bus.beat_is_hdr = acc && hdr_phase;
        bus.beat_is_pay = acc && (state == S_PAYLOAD);
        bus.beat_idx    = beat_cnt;
    end

    assign in_header  = (state == S_HEADER);
    assign in_payload = (state == S_PAYLOAD);
    assign in_drop    = (state == S_DROP);

    // Frame lifecycle: state, saturating beat counter, latched config and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            beat_cnt    <= '0;
            hdr_lat     <= '0;
            max_lat     <= '0;
            sticky_code <= ERR_OK;
        end else if (acc) begin
            if (idle) begin
                hdr_lat <= cfg_hdr_beats;
                max_lat <= cfg_max_beats;
            end
            if (bus.tlast) begin
                beat_cnt <= '0;
            end else if (beat_cnt != '1) begin
                beat_cnt <= beat_cnt + BEAT_ONE;
            end
            if (state == S_DROP) begin
                if (bus.tlast) begin
                    state       <= S_IDLE;
                    sticky_code <= ERR_OK;
                end
            end else if (bus.tlast) begin
                state       <= S_IDLE;
                sticky_code <= ERR_OK;
            end else if (abort || oversize) begin
                // Errors beat a coincident header end, so no PAYLOAD entry here
                state       <= S_DROP;
                sticky_code <= beat_code;
            end else if (hdr_phase && hdr_end) begin
                state <= S_PAYLOAD;
            end else if (idle) begin
                state <= S_HEADER;
            end
        end
    end

    // Saturating frame statistics; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_ok  <= '0;
            frames_err <= '0;
        end else if (clr_stats) begin
            frames_ok  <= '0;
            frames_err <= '0;
        end else if (bus.frame_end) begin
            if (bus.frame_err) begin
                if (frames_err != '1) begin
                    frames_err <= frames_err + STAT_ONE;
                end
            end else if (frames_ok != '1) begin
                frames_ok <= frames_ok + STAT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// tb/tb_frame_seq_ctrl.sv - self-checking bench for frame_seq_ctrl
module tb_frame_seq_ctrl;

    localparam int BW0 = 5;
    localparam int SW0 = 6;
    localparam int IDX_MAX0 = (1 << BW0) - 1;
    localparam int STAT_MAX0 = (1 << SW0) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    frame_seq_ctrl_if #(.BEAT_CNT_W(BW0)) bus0 ();
    frame_seq_ctrl_if #(.BEAT_CNT_W(16))  bus1 ();

    logic [3:0]       hdr0, hdr1;
    logic [BW0-1:0]   max0;
    logic [15:0]      max1;
    logic             clr0, clr1;
    logic             ih0, ip0, id0, ih1, ip1, id1;
    logic [SW0-1:0]   ok0, er0;
    logic [31:0]      ok1, er1;

    frame_seq_ctrl #(.BEAT_CNT_W(BW0), .HDR_CNT_W(4), .STAT_W(SW0), .EXT_HDR_DONE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .cfg_hdr_beats(hdr0), .cfg_max_beats(max0), .clr_stats(clr0),
        .in_header(ih0), .in_payload(ip0), .in_drop(id0),
        .frames_ok(ok0), .frames_err(er0)
    );

    frame_seq_ctrl #(.BEAT_CNT_W(16), .HDR_CNT_W(4), .STAT_W(32), .EXT_HDR_DONE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .cfg_hdr_beats(hdr1), .cfg_max_beats(max1), .clr_stats(clr1),
        .in_header(ih1), .in_payload(ip1), .in_drop(id1),
        .frames_ok(ok1), .frames_err(er1)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [22:0] pack_comb(input bit fs, input bit fe, input int ec,
                                              input bit bh, input bit bp, input int idx);
        return {fs, fe, (fe && ec != 0), 2'(ec), bh, bp, 16'(idx)};
    endfunction

    function automatic logic [66:0] pack_post(input bit h, input bit p, input bit d,
                                              input int ok, input int er);
        return {h, p, d, 32'(ok), 32'(er)};
    endfunction

    function automatic logic [22:0] act_comb0();
        return {bus0.frame_start, bus0.frame_end, bus0.frame_err, bus0.err_code,
                bus0.beat_is_hdr, bus0.beat_is_pay, 16'(bus0.beat_idx)};
    endfunction

    function automatic logic [22:0] act_comb1();
        return {bus1.frame_start, bus1.frame_end, bus1.frame_err, bus1.err_code,
                bus1.beat_is_hdr, bus1.beat_is_pay, bus1.beat_idx};
    endfunction

    function automatic logic [66:0] act_post0();
        return {ih0, ip0, id0, 32'(ok0), 32'(er0)};
    endfunction

    function automatic logic [66:0] act_post1();
        return {ih1, ip1, id1, ok1, er1};
    endfunction

    task automatic drive0(input bit acc, input bit tl, input bit te, input bit hd,
                          input int hdr, input int mx, input bit clr);
        @(negedge clk);
        bus0.beat_accept = acc;
        bus0.tlast       = tl;
        bus0.tuser_err   = te;
        bus0.header_done = hd;
        hdr0 = 4'(hdr);
        max0 = BW0'(mx);
        clr0 = clr;
        #1;
    endtask

    typedef struct {
        bit acc; bit tl; bit te; int hdr; int mx;
        bit fs; bit fe; int ec; bit bh; bit bp; int idx;
        bit nh; bit np; bit nd; int ok; int er;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit acc, input bit tl, input bit te, input int hdr, input int mx,
                       input bit fs, input bit fe, input int ec, input bit bh, input bit bp, input int idx,
                       input bit nh, input bit np, input bit nd, input int ok, input int er);
        vec_t v;
        v.acc = acc; v.tl = tl; v.te = te; v.hdr = hdr; v.mx = mx;
        v.fs = fs; v.fe = fe; v.ec = ec; v.bh = bh; v.bp = bp; v.idx = idx;
        v.nh = nh; v.np = np; v.nd = nd; v.ok = ok; v.er = er;
        vq.push_back(v);
    endtask

    // Frame-level reference model for dut0
    bit m_busy;
    bit m_pay;
    int m_drop;
    int m_idx;
    int m_hlen;
    int m_max;
    int m_ok;
    int m_er;
    int m_step;

    function automatic int sat_idx(input int v);
        return (v > IDX_MAX0) ? IDX_MAX0 : v;
    endfunction

    task automatic model_step(input bit acc, input bit tl, input bit te, input bit hd,
                              input int hdr, input int mx, input bit clr);
        bit fs, fe, bh, bp;
        int ec, code, idx_disp;
        fs = 0; fe = 0; bh = 0; bp = 0; ec = 0;
        drive0(acc, tl, te, hd, hdr, mx, clr);
        if (acc && !m_busy) begin
            fs = 1; m_busy = 1; m_pay = 0; m_drop = 0; m_idx = 0;
            m_hlen = (hdr == 0) ? 1 : hdr;
            m_max = mx;
        end
        idx_disp = sat_idx(m_idx);
        if (acc) begin
            if (m_drop != 0) begin
                if (tl) begin fe = 1; ec = m_drop; end
            end else begin
                bh = !m_pay;
                bp = m_pay;
                if (te) code = 3;
                else if (m_max != 0 && idx_disp >= m_max) code = 2;
                else if (tl && !m_pay) code = 1;
                else code = 0;
                if (tl) begin fe = 1; ec = code; end
                else if (code != 0) m_drop = code;
                else if (!m_pay && m_idx == m_hlen - 1) m_pay = 1;
            end
            if (tl) begin
                m_busy = 0; m_pay = 0; m_drop = 0; m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        if (clr) begin
            m_ok = 0; m_er = 0;
        end else if (fe) begin
            if (ec != 0) m_er = (m_er < STAT_MAX0) ? m_er + 1 : m_er;
            else         m_ok = (m_ok < STAT_MAX0) ? m_ok + 1 : m_ok;
        end
        check($sformatf("rnd%0d_comb", m_step), act_comb0(), pack_comb(fs, fe, ec, bh, bp, idx_disp));
        @(posedge clk);
        #1;
        check($sformatf("rnd%0d_post", m_step), act_post0(),
              pack_post(m_busy && !m_pay && m_drop == 0, m_busy && m_pay && m_drop == 0,
                        m_drop != 0, m_ok, m_er));
        m_step++;
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.beat_accept = 0; bus0.tlast = 0; bus0.tuser_err = 0; bus0.header_done = 0;
        bus1.beat_accept = 0; bus1.tlast = 0; bus1.tuser_err = 0; bus1.header_done = 0;
        hdr0 = 0; max0 = 0; clr0 = 0; hdr1 = 0; max1 = 0; clr1 = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_comb0", act_comb0(), pack_comb(0, 0, 0, 0, 0, 0));
        check("rst_post0", act_post0(), pack_post(0, 0, 0, 0, 0));
        check("rst_comb1", act_comb1(), pack_comb(0, 0, 0, 0, 0, 0));
        check("rst_post1", act_post1(), pack_post(0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        // acc tl te hdr mx | fs fe ec bh bp idx | nh np nd ok er
        add(1,0,0,2,0, 1,0,0,1,0,0, 1,0,0, 0,0);
        add(1,0,0,2,0, 0,0,0,1,0,1, 0,1,0, 0,0);
        add(0,0,0,2,0, 0,0,0,0,0,2, 0,1,0, 0,0);
        add(1,0,0,2,0, 0,0,0,0,1,2, 0,1,0, 0,0);
        add(1,0,0,2,0, 0,0,0,0,1,3, 0,1,0, 0,0);
        add(1,1,0,2,0, 0,1,0,0,1,4, 0,0,0, 1,0);
        add(0,0,0,2,0, 0,0,0,0,0,0, 0,0,0, 1,0);
        add(1,1,0,2,0, 1,1,1,1,0,0, 0,0,0, 1,1);
        add(1,0,0,2,4, 1,0,0,1,0,0, 1,0,0, 1,1);
        add(1,0,0,9,0, 0,0,0,1,0,1, 0,1,0, 1,1);
        add(1,0,0,9,0, 0,0,0,0,1,2, 0,1,0, 1,1);
        add(1,0,0,9,0, 0,0,0,0,1,3, 0,1,0, 1,1);
        add(1,0,0,9,0, 0,0,0,0,1,4, 0,0,1, 1,1);
        add(1,0,0,9,0, 0,0,0,0,0,5, 0,0,1, 1,1);
        add(1,1,0,9,0, 0,1,2,0,0,6, 0,0,0, 1,2);
        add(1,0,0,2,0, 1,0,0,1,0,0, 1,0,0, 1,2);
        add(1,0,0,2,0, 0,0,0,1,0,1, 0,1,0, 1,2);
        add(1,0,0,2,0, 0,0,0,0,1,2, 0,1,0, 1,2);
        add(1,0,1,2,0, 0,0,0,0,1,3, 0,0,1, 1,2);
        add(1,0,0,2,0, 0,0,0,0,0,4, 0,0,1, 1,2);
        add(1,0,1,2,0, 0,0,0,0,0,5, 0,0,1, 1,2);
        add(1,0,0,2,0, 0,0,0,0,0,6, 0,0,1, 1,2);
        add(1,1,0,2,0, 0,1,3,0,0,7, 0,0,0, 1,3);
        add(1,0,0,1,0, 1,0,0,1,0,0, 0,1,0, 1,3);
        add(1,0,0,1,0, 0,0,0,0,1,1, 0,1,0, 1,3);
        add(1,1,0,1,0, 0,1,0,0,1,2, 0,0,0, 2,3);
        add(1,0,0,0,0, 1,0,0,1,0,0, 0,1,0, 2,3);
        add(1,1,0,0,0, 0,1,0,0,1,1, 0,0,0, 3,3);
        add(1,0,0,2,0, 1,0,0,1,0,0, 1,0,0, 3,3);
        add(1,1,0,2,0, 0,1,1,1,0,1, 0,0,0, 3,4);
        add(1,0,1,1,0, 1,0,0,1,0,0, 0,0,1, 3,4);
        add(1,1,0,1,0, 0,1,3,0,0,1, 0,0,0, 3,5);
        add(1,0,0,3,1, 1,0,0,1,0,0, 1,0,0, 3,5);
        add(1,1,1,3,1, 0,1,3,1,0,1, 0,0,0, 3,6);
        add(1,0,0,3,1, 1,0,0,1,0,0, 1,0,0, 3,6);
        add(1,1,0,3,1, 0,1,2,1,0,1, 0,0,0, 3,7);

        foreach (vq[i]) begin
            drive0(vq[i].acc, vq[i].tl, vq[i].te, 0, vq[i].hdr, vq[i].mx, 0);
            check($sformatf("tbl%0d_comb", i), act_comb0(),
                  pack_comb(vq[i].fs, vq[i].fe, vq[i].ec, vq[i].bh, vq[i].bp, vq[i].idx));
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_post", i), act_post0(),
                  pack_post(vq[i].nh, vq[i].np, vq[i].nd, vq[i].ok, vq[i].er));
        end

        m_busy = 0; m_pay = 0; m_drop = 0; m_idx = 0; m_hlen = 1; m_max = 0;
        m_ok = 3; m_er = 7; m_step = 0;
        model_step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 1500; i++) begin
            bit acc, tl, te, clr;
            acc = ($urandom_range(0, 3) != 0);
            tl  = acc && ($urandom_range(0, ((i / 300) % 2 != 0) ? 63 : 7) == 0);
            te  = acc && ($urandom_range(0, 31) == 0);
            clr = ($urandom_range(0, 39) == 0);
            model_step(acc, tl, te, 1'($urandom), $urandom_range(0, 5),
                       ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, IDX_MAX0), clr);
        end

        model_step(1, 1, 0, 0, 2, 0, 1);
        model_step(0, 0, 0, 0, 2, 0, 1);
        for (int i = 0; i < 70; i++) model_step(1, 1, 0, 0, 2, 0, 0);
        check("stat_sat", {26'd0, ok0, er0}, {26'd0, 6'd0, 6'd63});
        model_step(1, 0, 0, 0, 1, 0, 0);
        model_step(1, 1, 0, 0, 1, 0, 0);
        model_step(1, 0, 0, 0, 1, 0, 0);
        model_step(1, 1, 0, 0, 1, 0, 1);
        check("clr_on_end", {26'd0, ok0, er0}, 96'd0);

        hdr1 = 4'd1;
        max1 = 16'd0;
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            bus1.beat_accept = 1; bus1.tlast = (b == 5); bus1.header_done = (b == 3);
            #1;
            check($sformatf("ext%0d_comb", b), act_comb1(),
                  pack_comb(b == 0, b == 5, 0, b <= 3, b >= 4, b));
            @(posedge clk);
            #1;
            check($sformatf("ext%0d_post", b), act_post1(),
                  pack_post(b < 3, b >= 3 && b < 5, 0, (b == 5) ? 1 : 0, 0));
            @(negedge clk);
            bus1.beat_accept = 0; bus1.tlast = 1; bus1.header_done = 1;
            #1;
            check($sformatf("gap%0d_comb", b), act_comb1(),
                  pack_comb(0, 0, 0, 0, 0, (b == 5) ? 0 : b + 1));
            @(posedge clk);
            #1;
            check($sformatf("gap%0d_post", b), act_post1(),
                  pack_post(b < 3, b >= 3 && b < 5, 0, (b == 5) ? 1 : 0, 0));
        end

        @(negedge clk);
        bus1.beat_accept = 1; bus1.tlast = 0; bus1.header_done = 1;
        @(negedge clk);
        bus1.header_done = 0;
        @(negedge clk);
        bus1.beat_accept = 0;
        #1;
        check("pre_rst_post1", act_post1(), pack_post(0, 1, 0, 1, 0));
        rst_n = 1'b0;
        #1;
        check("mid_rst_post1", act_post1(), pack_post(0, 0, 0, 0, 0));
        check("mid_rst_comb1", act_comb1(), pack_comb(0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus1.beat_accept = 1;
        #1;
        check("after_rst_comb1", act_comb1(), pack_comb(1, 0, 0, 1, 0, 0));
        @(posedge clk);
        #1;
        check("after_rst_post1", act_post1(), pack_post(1, 0, 0, 0, 0));
        bus1.beat_accept = 0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/frame_seq_ctrl.md
Name: frame_seq_ctrl

Overview:
Parametrised frame lifecycle controller for the parser datapath. It tracks IDLE, HEADER, PAYLOAD and DROP per AXI-Stream frame. The header/payload boundary comes either from a programmable header beat count or from an external header_done, selected by parameter. Adds per-beat qualifiers, a beat index, runt/oversize/abort detection, and saturating frame statistics. Sits between the ingress beat handshake and the header extractor/payload router.

Parameters:
BEAT_CNT_W, 16, width of beat index and max_frame_beats
HDR_CNT_W, 4, width of cfg_hdr_beats
STAT_W, 32, width of frame statistic counters
EXT_HDR_DONE, 0, 0 = header length from cfg_hdr_beats; 1 = header ends on the accepted beat with header_done=1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
beat_accept  in  1  tvalid&&tready, one accepted beat
tlast  in  1  last beat of frame, qualified by beat_accept
tuser_err  in  1  upstream abort marker, qualified by beat_accept
header_done  in  1  external header end; used only when EXT_HDR_DONE=1
cfg_hdr_beats  in  HDR_CNT_W  header length in beats; 0 is treated as 1
cfg_max_beats  in  BEAT_CNT_W  max legal frame length in beats; 0 = no limit
clr_stats  in  1  synchronous clear of statistics
frame_start  out  1  comb: first accepted beat of frame
frame_end  out  1  comb: accepted tlast beat
frame_err  out  1  comb: frame_end with error
err_code  out  2  comb, valid with frame_end: 0 OK, 1 RUNT, 2 OVERSIZE, 3 ABORT
beat_is_hdr  out  1  comb: accepted beat belongs to header
beat_is_pay  out  1  comb: accepted beat belongs to payload
beat_idx  out  BEAT_CNT_W  comb: index of current beat in frame (0 on frame_start beat)
in_header  out  1  state==HEADER
in_payload  out  1  state==PAYLOAD
in_drop  out  1  state==DROP
frames_ok  out  STAT_W  saturating count of good frames
frames_err  out  STAT_W  saturating count of errored frames

Behaviour:
- Reset (async): state=IDLE; beat counter, latched config, sticky error and both stats = 0. All comb outputs are then 0 with beat_accept=0.
- Config latch: cfg_hdr_beats and cfg_max_beats are used live on the frame_start beat and latched there. Changes mid-frame are ignored.
- beat_idx: 0 on the frame_start beat. Increments on each accepted beat; the registered count saturates at 2^BEAT_CNT_W-1.
- Header-end beat:
  - EXT_HDR_DONE=0: accepted beat with beat_idx == max(cfg_hdr_beats,1)-1.
  - EXT_HDR_DONE=1: accepted header beat with header_done=1.
- IDLE: on beat_accept, frame_start=1 and beat_is_hdr=1. Next state:
  - ABORT/OVERSIZE without tlast: DROP.
  - tlast: IDLE (frame_end=1).
  - header-end beat: PAYLOAD.
  - otherwise: HEADER.
- HEADER: accepted beats have beat_is_hdr=1. Header-end beat goes to PAYLOAD. tlast goes to IDLE.
- PAYLOAD: accepted beats have beat_is_pay=1. tlast goes to IDLE.
- DROP: accepted beats have beat_is_hdr=beat_is_pay=0. Stays in DROP until the tlast beat, then frame_end=1, frame_err=1, err_code=sticky code, next IDLE.
- Error detection, on every accepted beat outside DROP:
  - ABORT: tuser_err=1.
  - OVERSIZE: cfg_max_beats!=0 and beat_idx >= cfg_max_beats.
  - RUNT: tlast on a beat not in PAYLOAD state, including a single-beat frame and tlast on the header-end beat.
- Error priority and handling:
  - Priority ABORT > OVERSIZE > RUNT.
  - The first ABORT/OVERSIZE without tlast latches the sticky code and moves to DROP.
  - tuser_err in DROP is ignored.
- Simultaneous header-end and error: the error wins (DROP or runt end). There is no PAYLOAD entry.
- Statistics:
  - Registered, updated the cycle after frame_end.
  - frame_err=0 increments frames_ok; frame_err=1 increments frames_err.
  - Both saturate at all-ones.
  - clr_stats zeroes both; clr_stats has priority over a same-cycle increment.
- Cycles with beat_accept=0: no state change. All comb pulses = 0; beat_idx shows the next index.

Test Plan:
- EXT_HDR_DONE=0, cfg_hdr_beats=2, 5-beat frame, tlast on beat 4:
  - frame_start on beat 0; beat_is_hdr on beats 0-1; beat_is_pay on beats 2-4.
  - frame_end on beat 4, err_code=0; frames_ok=1.
- Single-beat frame (tlast on first beat):
  - frame_start and frame_end in the same cycle, err_code=1 (RUNT).
  - frames_err=1; state stays IDLE.
- cfg_max_beats=4, 7-beat frame:
  - Beat 4 flags OVERSIZE and goes to DROP; beats 5-6 have no hdr/pay qualifiers.
  - frame_end on beat 6 with err_code=2.
- tuser_err on payload beat 3 of an 8-beat frame:
  - DROP from beat 4; frame_end on beat 7 with err_code=3.
  - A following good frame is counted in frames_ok.
- EXT_HDR_DONE=1, header_done on beat 3, beat_accept gapped every other cycle:
  - in_payload asserts after beat 3 is accepted.
  - The state holds across idle cycles.
- Assert rst_n mid-PAYLOAD:
  - Immediately IDLE, stats=0.
  - The next accepted beat gives frame_start with beat_idx=0. Also cover clr_stats coincident with frame_end, which must leave 0.
